// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - programmable overlapping serial pattern detector with run control
module seq_detect_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    output logic             busy,
    output logic             hit,
    output logic             done_valid,
    input  logic             done_ack,
    output logic [CNT_W-1:0] hit_count,
    output logic             timed_out
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

    state_t            state, state_nxt;
    logic [PAT_W-1:0]  pat, pat_nxt;
    logic [CNT_W-1:0]  tgt, tgt_nxt;
    logic [WIN_W-1:0]  win, win_nxt;
    logic [PAT_W-1:0]  shreg, shreg_nxt;
    logic [FILL_W-1:0] fill, fill_nxt;
    logic [WIN_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic              timed_out_nxt, hit_nxt;

    logic [PAT_W-1:0]  shreg_upd;
    logic [FILL_W-1:0] fill_upd;
    logic [WIN_W-1:0]  bit_cnt_upd;
    logic [CNT_W-1:0]  count_upd;
    logic              match;

    // Abort wins over a bit offered in the same cycle, so ready drops with it.
    assign bit_ready  = (state == ARMED) && !abort;
    assign busy       = (state != IDLE);
    assign done_valid = (state == DONE);

    assign shreg_upd   = {shreg[PAT_W-2:0], bit_in};
    assign fill_upd    = (fill == FILL_FULL) ? fill : fill + 1'b1;
    assign bit_cnt_upd = (&bit_cnt) ? bit_cnt : bit_cnt + 1'b1;
    assign match       = (fill_upd == FILL_FULL) && (shreg_upd == pat);
    assign count_upd   = (match && !(&hit_count)) ? hit_count + 1'b1 : hit_count;

    always_comb begin
        state_nxt     = state;
        pat_nxt       = pat;
        tgt_nxt       = tgt;
        win_nxt       = win;
        shreg_nxt     = shreg;
        fill_nxt      = fill;
        bit_cnt_nxt   = bit_cnt;
        count_nxt     = hit_count;
        timed_out_nxt = timed_out;
        hit_nxt       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    pat_nxt       = cfg_pattern;
                    tgt_nxt       = cfg_target;
                    win_nxt       = cfg_window;
                    shreg_nxt     = '0;
                    fill_nxt      = '0;
                    bit_cnt_nxt   = '0;
                    count_nxt     = '0;
                    timed_out_nxt = 1'b0;
                    state_nxt     = ARMED;
                end
            end
            ARMED: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (bit_valid) begin
                    shreg_nxt   = shreg_upd;
                    fill_nxt    = fill_upd;
                    bit_cnt_nxt = bit_cnt_upd;
                    count_nxt   = count_upd;
                    hit_nxt     = match;
                    if (tgt != '0 && count_upd == tgt) begin
                        timed_out_nxt = 1'b0;
                        state_nxt     = DONE;
                    end else if (win != '0 && bit_cnt_upd == win) begin
                        timed_out_nxt = 1'b1;
                        state_nxt     = DONE;
                    end
                end
            end
            DONE: begin
                if (done_ack || abort) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            pat       <= '0;
            tgt       <= '0;
            win       <= '0;
            shreg     <= '0;
            fill      <= '0;
            bit_cnt   <= '0;
            hit_count <= '0;
            timed_out <= 1'b0;
            hit       <= 1'b0;
        end else begin
            state     <= state_nxt;
            pat       <= pat_nxt;
            tgt       <= tgt_nxt;
            win       <= win_nxt;
            shreg     <= shreg_nxt;
            fill      <= fill_nxt;
            bit_cnt   <= bit_cnt_nxt;
            hit_count <= count_nxt;
            timed_out <= timed_out_nxt;
            hit       <= hit_nxt;
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - directed self-checking bench for seq_detect_ctrl
module tb_seq_detect_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, abort;
    logic [3:0]  cfg_pattern;
    logic [7:0]  cfg_target;
    logic [15:0] cfg_window;
    logic        bit_valid, bit_in;
    logic        bit_ready, busy, hit, done_valid, done_ack, timed_out;
    logic [7:0]  hit_count;

    int n_checks = 0;
    int n_fail   = 0;

    seq_detect_ctrl #(.PAT_W(4), .CNT_W(8), .WIN_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .cfg_pattern(cfg_pattern), .cfg_target(cfg_target), .cfg_window(cfg_window),
        .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready), .busy(busy),
        .hit(hit), .done_valid(done_valid), .done_ack(done_ack),
        .hit_count(hit_count), .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [3:0] p, input logic [7:0] t, input logic [15:0] w);
        cfg_pattern = p;
        cfg_target  = t;
        cfg_window  = w;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ready", bit_ready, 1'b1);
        check("start_busy", busy, 1'b1);
    endtask

    // Bits go out oldest first; exp_hits uses the same ordering.
    task automatic send_seq(input string tag, input logic [15:0] bits,
                            input logic [15:0] exp_hits, input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1;
            bit_in    = bits[n-1-i];
            tick();
            bit_valid = 1'b0;
            check($sformatf("%s_hit%0d", tag, i + 1), hit, exp_hits[n-1-i]);
        end
    endtask

    task automatic ack_done();
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        check("ack_busy", busy, 1'b0);
        check("ack_done_valid", done_valid, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; done_ack = 1'b0;
        cfg_pattern = '0; cfg_target = '0; cfg_window = '0;
        bit_valid = 1'b0; bit_in = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_ready", bit_ready, 1'b0);
        check("rst_done", done_valid, 1'b0);
        check("rst_count", hit_count, 8'd0);
        reset_n = 1'b1;
        tick();

        // Overlap with window exhaustion; cfg changes after start must not matter
        start_run(4'b0110, 8'd0, 16'd7);
        cfg_pattern = 4'b1111;
        cfg_window  = 16'd0;
        send_seq("ovl", 16'b0110110, 16'b0001001, 7);
        check("ovl_done", done_valid, 1'b1);
        check("ovl_count", hit_count, 8'd2);
        check("ovl_timeout", timed_out, 1'b1);
        check("ovl_ready", bit_ready, 1'b0);

        // Result held while unacknowledged; start in DONE ignored
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            check($sformatf("hold_done%0d", i), done_valid, 1'b1);
            check($sformatf("hold_count%0d", i), hit_count, 8'd2);
            check($sformatf("hold_hit%0d", i), hit, 1'b0);
        end
        start = 1'b0;
        ack_done();
        check("idle_count_kept", hit_count, 8'd2);

        // Target stop; further bits refused; start alongside ack ignored
        start_run(4'b0110, 8'd1, 16'd0);
        send_seq("tgt", 16'b0110, 16'b0001, 4);
        check("tgt_done", done_valid, 1'b1);
        check("tgt_count", hit_count, 8'd1);
        check("tgt_timeout", timed_out, 1'b0);
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        #1;
        check("tgt_bit5_ready", bit_ready, 1'b0);
        tick();
        bit_valid = 1'b0;
        check("tgt_bit5_count", hit_count, 8'd1);
        start = 1'b1;
        ack_done();
        start = 1'b0;
        tick();
        check("ack_start_ignored", busy, 1'b0);

        // Target and window on the same bit: target wins
        start_run(4'b0110, 8'd1, 16'd4);
        send_seq("tie", 16'b0110, 16'b0001, 4);
        check("tie_done", done_valid, 1'b1);
        check("tie_count", hit_count, 8'd1);
        check("tie_timeout", timed_out, 1'b0);
        ack_done();

        // Fill guard: all-zero pattern against cleared shift register
        start_run(4'b0000, 8'd0, 16'd0);
        send_seq("fill", 16'b00000, 16'b00011, 5);
        check("fill_count", hit_count, 8'd2);
        check("fill_busy", busy, 1'b1);
        check("fill_done", done_valid, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("fill_abort_busy", busy, 1'b0);

        // Abort mid-run with a bit offered
        start_run(4'b0110, 8'd0, 16'd0);
        send_seq("abt", 16'b01, 16'b00, 2);
        abort     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        #1;
        check("abt_ready", bit_ready, 1'b0);
        tick();
        abort     = 1'b0;
        bit_valid = 1'b0;
        check("abt_busy", busy, 1'b0);
        check("abt_done", done_valid, 1'b0);
        check("abt_hit", hit, 1'b0);
        check("abt_count", hit_count, 8'd0);

        // Reset while in DONE clears everything
        start_run(4'b0110, 8'd0, 16'd7);
        send_seq("rd", 16'b0110110, 16'b0001001, 7);
        check("rd_done", done_valid, 1'b1);
        reset_n = 1'b0;
        tick();
        check("rd_busy", busy, 1'b0);
        check("rd_done_valid", done_valid, 1'b0);
        check("rd_hit", hit, 1'b0);
        check("rd_count", hit_count, 8'd0);
        check("rd_timeout", timed_out, 1'b0);
        check("rd_ready", bit_ready, 1'b0);
        reset_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
